// File: rtl/div_iter_param_pkg.sv
// rtl/div_iter_param_pkg.sv - shared op encoding, FSM states and constants for the iterative divider
package div_iter_param_pkg;

    localparam int ADDR_BITS = 4;
    localparam int XLEN_MAX  = 64;

    typedef enum logic [3:0] {
        FU_ADD  = 4'd0,
        FU_SUB  = 4'd1,
        FU_MUL  = 4'd4,
        FU_DIV  = 4'd8,
        FU_DIVU = 4'd9,
        FU_REM  = 4'd10,
        FU_REMU = 4'd11
    } fu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic logic is_signed_op(input fu_op_t op);
        return (op == FU_DIV) || (op == FU_REM);
    endfunction

endpackage

// File: rtl/div_iter_param_if.sv
// rtl/div_iter_param_if.sv - request/result handshake bundle between issue logic and the divider
interface div_iter_param_if
    import div_iter_param_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ID_BITS = ADDR_BITS
) ();

    logic               in_vld_i;
    logic               in_rdy_o;
    fu_op_t             op_i;
    logic [XLEN-1:0]    op1_i;
    logic [XLEN-1:0]    op2_i;
    logic [ID_BITS-1:0] trans_id_i;
    logic               out_vld_o;
    logic               out_rdy_i;
    logic [ID_BITS-1:0] trans_id_o;
    logic [XLEN-1:0]    result_o;

    modport master (
        output in_vld_i, op_i, op1_i, op2_i, trans_id_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, trans_id_o, result_o
    );

    modport slave (
        input  in_vld_i, op_i, op1_i, op2_i, trans_id_i, out_rdy_i,
        output in_rdy_o, out_vld_o, trans_id_o, result_o
    );

endinterface

// File: rtl/div_iter_param_lzc.sv
// rtl/div_iter_param_lzc.sv - leading (MODE=1) or trailing (MODE=0) zero counter
module div_iter_param_lzc #(
    parameter int WIDTH = 32,
    parameter bit MODE  = 1'b1
) (
    input  logic [WIDTH-1:0]         i_data,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_empty
);

    localparam int CW = $clog2(WIDTH);

    // Later hits overwrite earlier ones, so the scan order selects leading vs trailing.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE) begin
                if (i_data[i]) o_cnt = CW'(WIDTH - 1 - i);
            end else begin
                if (i_data[WIDTH-1-i]) o_cnt = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign o_empty = ~|i_data;

endmodule

// File: rtl/div_iter_param.sv
// rtl/div_iter_param.sv - radix-2 restoring DIV/DIVU/REM/REMU with leading-zero skip; DIV_EARLY_OUT_EN adds PREP shortcuts
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ID_BITS = ADDR_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_ex_i,
    div_iter_param_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int LW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    fu_op_t             r_op;
    logic [ID_BITS-1:0] r_id;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN:0]      r_rem;
    logic [CW-1:0]      r_cnt;
    logic [XLEN-1:0]    r_result;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic [LW-1:0]      w_lz;
    logic               w_a_zero;
    logic [CW-1:0]      w_n;
    logic [XLEN+1:0]    w_trial;
    logic               w_ge;
    logic               w_div0;
    logic               w_b_one;
    logic               w_ovf;
    logic               w_early;
    logic [XLEN-1:0]    w_qm;
    logic [XLEN-1:0]    w_rm;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_result;
    logic               w_load_result;

    assign w_accept = bus.in_vld_i & bus.in_rdy_o & ~flush_ex_i;
    assign w_sa     = is_signed_op(bus.op_i) & bus.op1_i[XLEN-1];
    assign w_sb     = is_signed_op(bus.op_i) & bus.op2_i[XLEN-1];
    assign w_abs_a  = w_sa ? -bus.op1_i : bus.op1_i;
    assign w_abs_b  = w_sb ? -bus.op2_i : bus.op2_i;

    div_iter_param_lzc #(
        .WIDTH (XLEN),
        .MODE  (1'b1)
    ) u_lzc (
        .i_data  (r_a),
        .o_cnt   (w_lz),
        .o_empty (w_a_zero)
    );

    assign w_n = w_a_zero ? '0 : (CW'(XLEN) - CW'(w_lz));

    // r_a doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom.
    assign w_trial = {r_rem, r_a[XLEN-1]} - {2'b00, r_b};
    assign w_ge    = ~w_trial[XLEN+1];

    assign w_div0  = (r_b == '0);
    assign w_b_one = (r_b == XLEN'(1));
    assign w_ovf   = r_sign_a & r_sign_b & w_b_one & (r_op1 == MIN_NEG);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = w_div0 | w_b_one | (r_a < r_b);
    assign w_qm    = (r_state == PREP) ? (w_b_one ? r_a : '0) : r_a;
    assign w_rm    = (r_state == PREP) ? ((r_a < r_b) ? r_a : '0) : r_rem[XLEN-1:0];
`else
    assign w_early = 1'b0;
    assign w_qm    = r_a;
    assign w_rm    = r_rem[XLEN-1:0];
`endif

    always_comb begin
        w_quo    = w_qm;
        w_rem    = w_rm;
        w_result = '0;
        if (w_div0) begin
            w_quo = '1;
            w_rem = r_op1;
        end else if (w_ovf) begin
            w_quo = r_op1;
            w_rem = '0;
        end else begin
            if (r_sign_a ^ r_sign_b) w_quo = -w_qm;
            if (r_sign_a)            w_rem = -w_rm;
        end
        case (r_op)
            FU_DIV, FU_DIVU: w_result = w_quo;
            FU_REM, FU_REMU: w_result = w_rem;
            default:         w_result = '0;
        endcase
    end

    assign w_load_result = ~flush_ex_i & ((r_state == FIX) | ((r_state == PREP) & w_early));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = PREP;
            PREP: begin
                if (w_early)       w_state_nxt = DONE;
                else if (w_a_zero) w_state_nxt = FIX;
                else               w_state_nxt = CALC;
            end
            CALC: if (r_cnt == CW'(1)) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (bus.out_rdy_i) w_state_nxt = w_accept ? PREP : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_ex_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_op     <= FU_ADD;
            r_id     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_op1    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= bus.op_i;
                r_id     <= bus.trans_id_i;
                r_sign_a <= w_sa;
                r_sign_b <= w_sb;
                r_op1    <= bus.op1_i;
                r_a      <= w_abs_a;
                r_b      <= w_abs_b;
            end
            if (r_state == PREP) begin
                r_a   <= r_a << w_lz;
                r_rem <= '0;
                r_cnt <= w_n;
            end
            if (r_state == CALC) begin
                r_a   <= {r_a[XLEN-2:0], w_ge};
                r_rem <= w_ge ? w_trial[XLEN:0] : {r_rem[XLEN-1:0], r_a[XLEN-1]};
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_load_result) r_result <= w_result;
        end
    end

    assign bus.in_rdy_o   = (r_state == IDLE) | ((r_state == DONE) & bus.out_rdy_i);
    assign bus.out_vld_o  = (r_state == DONE);
    assign bus.result_o   = r_result;
    assign bus.trans_id_o = r_id;

endmodule

// File: tb/tb_div_iter_param.sv
// tb/tb_div_iter_param.sv - scoreboard bench for div_iter_param (XLEN 32 and 64 instances)
module tb_div_iter_param;
    import div_iter_param_pkg::*;

    localparam int IDW = ADDR_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic flush64 = 1'b0;
    always #5 clk = ~clk;

    div_iter_param_if #(.XLEN(32), .ID_BITS(IDW)) u_if ();
    div_iter_param_if #(.XLEN(64), .ID_BITS(IDW)) u_if64 ();

    div_iter_param #(.XLEN(32), .ID_BITS(IDW)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_ex_i(flush), .bus(u_if)
    );
    div_iter_param #(.XLEN(64), .ID_BITS(IDW)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .flush_ex_i(flush64), .bus(u_if64)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    res;
        int             cyc;
        int             lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    bit   seen_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input fu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == FU_DIV || op == FU_REM) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        case (op)
            FU_DIV, FU_DIVU: return q;
            FU_REM, FU_REMU: return r;
            default:         return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input fu_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        logic [31:0] ma, mb;
        int n;
        sgn = (op == FU_DIV || op == FU_REM);
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (mb == 32'd0 || mb == 32'd1 || ma < mb) return 2;
`endif
        n = 0;
        for (int i = 0; i < 32; i++) if (ma[i]) n = i + 1;
        return 3 + n;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 1));
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic issue(input fu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [IDW-1:0] id, input logic [31:0] exp, input bit track);
        int waitn;
        waitn = 0;
        @(negedge clk);
        u_if.in_vld_i   = 1'b1;
        u_if.op_i       = op;
        u_if.op1_i      = a;
        u_if.op2_i      = b;
        u_if.trans_id_i = id;
        #1;
        while (!u_if.in_rdy_o && waitn < 300) begin
            @(negedge clk);
            #1;
            waitn++;
        end
        if (!u_if.in_rdy_o) check("issue_timeout", 0, 1);
        else if (track) sb_q.push_back('{id, exp, cyc, ref_lat(op, a, b)});
        @(posedge clk);
        #1;
        u_if.in_vld_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run64(input fu_op_t op, input logic [IDW-1:0] id, input logic [63:0] exp);
        int c0;
        int n;
        @(negedge clk);
        u_if64.in_vld_i   = 1'b1;
        u_if64.op_i       = op;
        u_if64.op1_i      = 64'hFFFF_FFFF_FFFF_FFFF;
        u_if64.op2_i      = 64'h0000_0001_0000_0000;
        u_if64.trans_id_i = id;
        #1;
        check("rdy64", u_if64.in_rdy_o, 1);
        c0 = cyc;
        @(posedge clk);
        #1;
        u_if64.in_vld_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!u_if64.out_vld_o && n < 100);
        check("lat64", 64'(cyc - c0), 67);
        check("res64", u_if64.result_o, exp);
        check("id64", u_if64.trans_id_o, id);
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (u_if.out_vld_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_vld", 1, 0);
                end else begin
                    if (!seen_vld) begin
                        seen_vld = 1'b1;
                        check("latency", 64'(cyc - sb_q[0].cyc), 64'(sb_q[0].lat));
                    end
                    if (u_if.out_rdy_i) begin
                        e = sb_q.pop_front();
                        check("result", u_if.result_o, e.res);
                        check("trans_id", u_if.trans_id_o, e.id);
                        seen_vld = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rdy_rand) u_if.out_rdy_i = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        fu_op_t op;
        logic [31:0] a, b;

        u_if.in_vld_i = 1'b0; u_if.op_i = FU_DIVU; u_if.op1_i = '0; u_if.op2_i = '0;
        u_if.trans_id_i = '0; u_if.out_rdy_i = 1'b1;
        u_if64.in_vld_i = 1'b0; u_if64.op_i = FU_DIVU; u_if64.op1_i = '0; u_if64.op2_i = '0;
        u_if64.trans_id_i = '0; u_if64.out_rdy_i = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_vld", u_if.out_vld_o, 0);
        check("rst_in_rdy", u_if.in_rdy_o, 1);
        check("rst_result", u_if.result_o, 0);
        check("rst_trans_id", u_if.trans_id_o, 0);
        rst = 1'b0;

        issue(FU_DIVU, 32'd100, 32'd7, 4'd1, 32'd14, 1'b1);
        issue(FU_REMU, 32'd100, 32'd7, 4'd2, 32'd2, 1'b1);
        issue(FU_DIV,  32'hFFFF_FFF9, 32'd2, 4'd3, 32'hFFFF_FFFD, 1'b1);
        issue(FU_REM,  32'hFFFF_FFF9, 32'd2, 4'd4, 32'hFFFF_FFFF, 1'b1);
        issue(FU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 32'h8000_0000, 1'b1);
        issue(FU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 32'd0, 1'b1);
        issue(FU_DIVU, 32'd5, 32'd0, 4'd7, 32'hFFFF_FFFF, 1'b1);
        issue(FU_REMU, 32'd5, 32'd0, 4'd8, 32'd5, 1'b1);
        issue(FU_DIVU, 32'd0, 32'd5, 4'd9, 32'd0, 1'b1);
        issue(FU_ADD,  32'd10, 32'd3, 4'd10, 32'd0, 1'b1);
        issue(FU_REM,  32'd7, 32'hFFFF_FFFE, 4'd11, 32'd1, 1'b1);
        wait_idle();

        @(negedge clk);
        u_if.out_rdy_i = 1'b0;
        issue(FU_DIVU, 32'd50, 32'd5, 4'd5, 32'd10, 1'b1);
        n = 0;
        while (!u_if.out_vld_o && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("hold_first_vld", u_if.out_vld_o, 1);
        @(negedge clk);
        u_if.in_vld_i = 1'b1; u_if.op_i = FU_DIVU; u_if.op1_i = 32'd81; u_if.op2_i = 32'd9;
        u_if.trans_id_i = 4'd6;
        for (int k = 0; k < 5; k++) begin
            #3;
            check("hold_result", u_if.result_o, 10);
            check("hold_trans_id", u_if.trans_id_o, 5);
            check("hold_vld", u_if.out_vld_o, 1);
            check("hold_in_rdy", u_if.in_rdy_o, 0);
            @(negedge clk);
        end
        u_if.out_rdy_i = 1'b1;
        #1;
        check("b2b_in_rdy", u_if.in_rdy_o, 1);
        sb_q.push_back('{4'd6, 32'd9, cyc, ref_lat(FU_DIVU, 32'd81, 32'd9)});
        @(posedge clk);
        #1;
        u_if.in_vld_i = 1'b0;
        wait_idle();

        issue(FU_DIVU, 32'hFFFF_FFFF, 32'd3, 4'd7, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_rdy", u_if.in_rdy_o, 1);
        check("flush_out_vld", u_if.out_vld_o, 0);
        repeat (40) @(negedge clk);
        issue(FU_DIVU, 32'd9, 32'd3, 4'd8, 32'd3, 1'b1);
        wait_idle();

        issue(FU_DIVU, 32'hFFFF_FFFF, 32'd3, 4'd9, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_vld", u_if.out_vld_o, 0);
        check("midrst_in_rdy", u_if.in_rdy_o, 1);
        check("midrst_result", u_if.result_o, 0);
        check("midrst_trans_id", u_if.trans_id_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 8))
                0, 1:    op = FU_DIV;
                2, 3:    op = FU_DIVU;
                4, 5:    op = FU_REM;
                6, 7:    op = FU_REMU;
                default: op = FU_MUL;
            endcase
            a = rnd_opnd();
            b = rnd_opnd();
            issue(op, a, b, 4'(i), ref_div(op, a, b), 1'b1);
        end
        wait_idle();
        rdy_rand = 1'b0;
        @(negedge clk);
        u_if.out_rdy_i = 1'b1;

        run64(FU_DIVU, 4'd3, 64'h0000_0000_FFFF_FFFF);
        run64(FU_REMU, 4'd4, 64'h0000_0000_FFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
